// File: rtl/conv_layer_pkg.sv
// Shared types and constants for the conv-layer window slider.
// Word slicing is MSB-first: word 0 sits in the top DATA_WIDTH bits.
package conv_layer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SLIDE   = 2'd2,
      DONE    = 2'd3
   } slider_state_t;

   localparam int KERNEL_SIZE  = 3;
   localparam int WINDOW_WORDS = KERNEL_SIZE * KERNEL_SIZE;

   // LSB position of word idx in an n_words vector of dw-bit words, word 0 at the MSB
   function automatic int unsigned word_lsb(input int unsigned idx,
                                            input int unsigned n_words,
                                            input int unsigned dw);
      return (n_words - 1 - idx) * dw;
   endfunction

endpackage

// File: rtl/conv_layer_window_slider_if.sv
// Buffer row-select, window handshake and control signals of the window slider.
// slave = the slider itself, master = the controller / buffer / PE side.
interface conv_layer_window_slider_if #(
   parameter int DATA_WIDTH       = 32,
   parameter int BUFFER_ROW_WIDTH = 2,
   parameter int BUFFER_COL       = 8,
   parameter int BUFFER_COL_WIDTH = 3,
   parameter int KERNEL_SIZE      = 3
);
   logic                                              start;
   logic                                              flush;
   logic [BUFFER_COL*DATA_WIDTH-1:0]                  row_bus_in;
   logic [BUFFER_ROW_WIDTH-1:0]                       row_index;
   logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     window_out;
   logic                                              window_valid;
   logic                                              window_ready;
   logic [BUFFER_COL_WIDTH-1:0]                       col_pos;
   logic                                              busy;
   logic                                              done;

   modport slave (
      input  start, flush, row_bus_in, window_ready,
      output row_index, window_out, window_valid, col_pos, busy, done
   );

   modport master (
      output start, flush, row_bus_in, window_ready,
      input  row_index, window_out, window_valid, col_pos, busy, done
   );
endinterface

// File: rtl/conv_window_row_shifter.sv
// One buffer row held locally: parallel load, one-word left shift with zero fill,
// and the leftmost KERNEL_SIZE words exposed as the window tap.
module conv_window_row_shifter
   import conv_layer_pkg::word_lsb;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int BUFFER_COL  = 8,
   parameter int KERNEL_SIZE = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load,
   input  logic                              shift,
   input  logic [BUFFER_COL*DATA_WIDTH-1:0]  row_in,
   output logic [KERNEL_SIZE*DATA_WIDTH-1:0] tap_out
);
   localparam int ROW_W = BUFFER_COL * DATA_WIDTH;

   logic [ROW_W-1:0] row_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        row_q <= '0;
      else if (load)  row_q <= row_in;
      else if (shift) row_q <= {row_q[ROW_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
   end

   assign tap_out = row_q[word_lsb(KERNEL_SIZE-1, BUFFER_COL, DATA_WIDTH) +: KERNEL_SIZE*DATA_WIDTH];

endmodule

// File: rtl/conv_layer_window_slider.sv
// Captures the buffer's rows through row_index, then slides a KxK window across
// the columns, one window per valid/ready transfer.
module conv_layer_window_slider #(
   parameter int DATA_WIDTH       = 32,
   parameter int BUFFER_ROW       = 3,
   parameter int BUFFER_ROW_WIDTH = 2,
   parameter int BUFFER_COL       = 8,
   parameter int BUFFER_COL_WIDTH = 3,
   parameter int KERNEL_SIZE      = conv_layer_pkg::KERNEL_SIZE
) (
   input  logic                        clk,
   input  logic                        rst,
   conv_layer_window_slider_if.slave   bus
);
   import conv_layer_pkg::*;

   localparam logic [BUFFER_ROW_WIDTH-1:0] LAST_ROW = BUFFER_ROW_WIDTH'(BUFFER_ROW - 1);
   localparam logic [BUFFER_COL_WIDTH-1:0] LAST_COL = BUFFER_COL_WIDTH'(BUFFER_COL - KERNEL_SIZE);

   slider_state_t                 state_q;
   logic [BUFFER_ROW_WIDTH-1:0]   row_index_q;
   logic [BUFFER_COL_WIDTH-1:0]   col_pos_q;
   logic                          valid_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          xfer;
   logic                          cap_en;
   logic                          shift_en;

   logic [0:BUFFER_ROW-1][KERNEL_SIZE*DATA_WIDTH-1:0] taps;

   assign xfer     = valid_q & bus.window_ready;
   assign cap_en   = (state_q == CAPTURE) & ~bus.flush;
   assign shift_en = (state_q == SLIDE) & xfer & ~bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         row_index_q <= '0;
         col_pos_q   <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (bus.flush) begin
         // abort wins over start and any transfer; captured rows are left as-is
         state_q     <= IDLE;
         row_index_q <= '0;
         col_pos_q   <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q     <= CAPTURE;
                  row_index_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            CAPTURE: begin
               if (row_index_q == LAST_ROW) begin
                  state_q     <= SLIDE;
                  row_index_q <= '0;
                  col_pos_q   <= '0;
                  valid_q     <= 1'b1;
               end else begin
                  row_index_q <= row_index_q + 1'b1;
               end
            end
            SLIDE: begin
               if (xfer) begin
                  col_pos_q <= col_pos_q + 1'b1;
                  if (col_pos_q == LAST_COL) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q   <= IDLE;
               col_pos_q <= '0;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar r = 0; r < BUFFER_ROW; r++) begin : g_row
      conv_window_row_shifter #(
         .DATA_WIDTH  (DATA_WIDTH),
         .BUFFER_COL  (BUFFER_COL),
         .KERNEL_SIZE (KERNEL_SIZE)
      ) u_row (
         .clk     (clk),
         .rst     (rst),
         .load    (cap_en && (row_index_q == BUFFER_ROW_WIDTH'(r))),
         .shift   (shift_en),
         .row_in  (bus.row_bus_in),
         .tap_out (taps[r])
      );
   end

   // taps[0] is the top kernel row, so the packed array is already row-major
   assign bus.window_out   = taps;
   assign bus.row_index    = row_index_q;
   assign bus.col_pos      = col_pos_q;
   assign bus.window_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule
